// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE-array row controller.
package pe_ctrl_pkg;

    localparam int NUM_PE_DEF   = 3;
    localparam int IF_WORDS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILT,
        LOAD_IF,
        START,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_array_controller_if.sv
// Control/status bundle between the controller (master) and the PE row datapath (slave).
interface pe_array_controller_if #(
    parameter int NUM_PE = pe_ctrl_pkg::NUM_PE_DEF
);
    logic              start_PE;
    logic              mode;
    logic              filt_len;
    logic              stride_len;
    logic              sel_addr_SRAM;
    logic              filt_cnt_en;
    logic              ifg_cnt_en;
    logic [NUM_PE-1:0] ifmap_wen;
    logic              co_onehot;
    logic              co_ifG;
    logic              done_all;
    logic              res_empty;

    modport master (
        output start_PE, mode, filt_len, stride_len, sel_addr_SRAM,
               filt_cnt_en, ifg_cnt_en, ifmap_wen,
        input  co_onehot, co_ifG, done_all, res_empty
    );

    modport slave (
        input  start_PE, mode, filt_len, stride_len, sel_addr_SRAM,
               filt_cnt_en, ifg_cnt_en, ifmap_wen,
        output co_onehot, co_ifG, done_all, res_empty
    );
endinterface

// File: rtl/pe_ctrl_watchdog.sv
// Clearable saturating up-counter; expired is high once the count reaches all-ones.
module pe_ctrl_watchdog #(
    parameter int WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WIDTH-1:0] cnt_q;

    assign expired = &cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !expired) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pe_array_controller.sv
// Sequences the chained-PE row through a convolution job: filter load, per-round
// ifmap load, PE start, completion wait and psum drain.
module pe_array_controller
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_PE      = NUM_PE_DEF,
    parameter int IF_WORDS    = IF_WORDS_DEF,
    parameter int ROUND_W     = 4,
    parameter int DRAIN_QUIET = 4,
    parameter int TIMEOUT_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cfg_mode,
    input  logic                   cfg_filt_len,
    input  logic                   cfg_stride_len,
    input  logic [ROUND_W-1:0]     cfg_rounds,
    pe_array_controller_if.master  dp,
    output logic                   busy,
    output logic                   job_done,
    output logic                   timeout_err
);

    localparam int WORD_W  = cnt_width(IF_WORDS);
    localparam int PE_W    = cnt_width(NUM_PE);
    localparam int QUIET_W = cnt_width(DRAIN_QUIET);

    localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(IF_WORDS - 1);
    localparam logic [PE_W-1:0]    PE_LAST    = PE_W'(NUM_PE - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(DRAIN_QUIET - 1);

    state_t               state_q, state_d;
    logic [WORD_W-1:0]    word_cnt_q;
    logic [PE_W-1:0]      pe_idx_q;
    logic [QUIET_W-1:0]   quiet_cnt_q;
    logic [ROUND_W-1:0]   round_cnt_q;
    logic [ROUND_W-1:0]   rounds_q;
    logic                 mode_q, filt_len_q, stride_len_q;
    logic                 ifg_seen_q;
    logic                 timeout_q;

    logic                 accept;
    logic                 abort_now;
    logic                 more_rounds;
    logic [ROUND_W:0]     rounds_eff;
    logic                 wd_clr, wd_inc, wd_expired;
    logic                 to_timeout;
    logic                 drain_exit;
    logic                 filt_en, ifg_en, sel_sram, start_pe, done_pulse;
    logic [NUM_PE-1:0]    wen;

    assign accept    = (state_q == IDLE) && start;
    assign abort_now = abort && (state_q != IDLE);

    // A programmed round count of zero still runs one round.
    assign rounds_eff  = (rounds_q == '0) ? (ROUND_W+1)'(1) : {1'b0, rounds_q};
    assign more_rounds = (({1'b0, round_cnt_q} + (ROUND_W+1)'(1)) < rounds_eff);

    pe_ctrl_watchdog #(.WIDTH(TIMEOUT_W)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    // NOTE: state and counters update with <= so every register samples the
    // pre-edge values; blocking writes here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        filt_en    = 1'b0;
        ifg_en     = 1'b0;
        sel_sram   = 1'b0;
        wen        = '0;
        start_pe   = 1'b0;
        done_pulse = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        to_timeout = 1'b0;
        drain_exit = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_FILT;
            end
            LOAD_FILT: begin
                filt_en = 1'b1;
                if (dp.co_onehot) state_d = LOAD_IF;
            end
            LOAD_IF: begin
                sel_sram = 1'b1;
                ifg_en   = 1'b1;
                wen      = NUM_PE'(1) << pe_idx_q;
                if (word_cnt_q == WORD_LAST && pe_idx_q == PE_LAST) state_d = START;
            end
            START: begin
                start_pe = 1'b1;
                wd_clr   = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                wd_inc = 1'b1;
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (dp.done_all) begin
                    state_d = DRAIN;
                end else if (wd_expired) begin
                    to_timeout = 1'b1;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (dp.res_empty && quiet_cnt_q == QUIET_LAST) begin
                    drain_exit = 1'b1;
                    state_d    = (more_rounds && !(ifg_seen_q || dp.co_ifG)) ? LOAD_IF : FINISH;
                end
            end
            FINISH: begin
                done_pulse = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_now) begin
            state_d    = IDLE;
            done_pulse = 1'b0;
            to_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q       <= 1'b0;
            filt_len_q   <= 1'b0;
            stride_len_q <= 1'b0;
            rounds_q     <= '0;
            round_cnt_q  <= '0;
            ifg_seen_q   <= 1'b0;
            timeout_q    <= 1'b0;
            word_cnt_q   <= '0;
            pe_idx_q     <= '0;
            quiet_cnt_q  <= '0;
        end else begin
            if (accept) begin
                mode_q       <= cfg_mode;
                filt_len_q   <= cfg_filt_len;
                stride_len_q <= cfg_stride_len;
                rounds_q     <= cfg_rounds;
                round_cnt_q  <= '0;
                ifg_seen_q   <= 1'b0;
                timeout_q    <= 1'b0;
            end else begin
                if (dp.co_ifG)  ifg_seen_q  <= 1'b1;
                if (to_timeout) timeout_q   <= 1'b1;
                if (drain_exit) round_cnt_q <= round_cnt_q + ROUND_W'(1);
            end

            // Word/PE pointers wrap to zero after the last PE so a later round restarts cleanly.
            if (accept || abort_now) begin
                word_cnt_q <= '0;
                pe_idx_q   <= '0;
            end else if (state_q == LOAD_IF) begin
                if (word_cnt_q == WORD_LAST) begin
                    word_cnt_q <= '0;
                    pe_idx_q   <= (pe_idx_q == PE_LAST) ? '0 : pe_idx_q + PE_W'(1);
                end else begin
                    word_cnt_q <= word_cnt_q + WORD_W'(1);
                end
            end

            if (state_q != DRAIN || abort || !dp.res_empty) begin
                quiet_cnt_q <= '0;
            end else if (quiet_cnt_q != QUIET_LAST) begin
                quiet_cnt_q <= quiet_cnt_q + QUIET_W'(1);
            end
        end
    end

    assign dp.start_PE      = start_pe;
    assign dp.mode          = mode_q;
    assign dp.filt_len      = filt_len_q;
    assign dp.stride_len    = stride_len_q;
    assign dp.sel_addr_SRAM = sel_sram;
    assign dp.filt_cnt_en   = filt_en;
    assign dp.ifg_cnt_en    = ifg_en;
    assign dp.ifmap_wen     = wen;

    assign busy        = (state_q != IDLE);
    assign job_done    = done_pulse;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pe_array_controller.sv
// Self-checking bench for pe_array_controller: table-driven jobs with a datapath
// model and an ifmap write-enable scoreboard, plus reset and abort sequences.
module tb_pe_array_controller;
    import pe_ctrl_pkg::*;

    localparam int NP  = 3;
    localparam int IFW = 8;
    localparam int RW  = 4;
    localparam int DQ  = 4;
    // Short enough for a quick timeout job, long enough to outlast a 20-cycle done_all delay.
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, abort = 1'b0;
    logic          cfg_mode = 1'b0, cfg_filt_len = 1'b0, cfg_stride_len = 1'b0;
    logic [RW-1:0] cfg_rounds = '0;
    logic          busy, job_done, timeout_err;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_array_controller_if #(.NUM_PE(NP)) dp_if ();

    pe_array_controller #(
        .NUM_PE(NP), .IF_WORDS(IFW), .ROUND_W(RW), .DRAIN_QUIET(DQ), .TIMEOUT_W(TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_mode       (cfg_mode),
        .cfg_filt_len   (cfg_filt_len),
        .cfg_stride_len (cfg_stride_len),
        .cfg_rounds     (cfg_rounds),
        .dp             (dp_if),
        .busy           (busy),
        .job_done       (job_done),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        int         rounds;
        int         onehot_at;   // filt_cnt_en cycle on which co_onehot fires
        int         done_at;     // cycles after start_PE for done_all; 0 = never
        int         ifg_round;   // round whose last ifmap word raises co_ifG; 0 = never
        int         toggle;      // drive res_empty 1,1,0,1,1,1,1 in DRAIN
        logic [2:0] cfg;         // {mode, filt_len, stride_len}
        int         exp_starts;
        int         exp_jd;
        int         exp_to;
        int         exp_gap;     // cycles from done_all to job_done
    } vec_t;

    logic [NP-1:0] exp_wen_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({dp_if.start_PE, dp_if.mode, dp_if.filt_len, dp_if.stride_len,
                    dp_if.sel_addr_SRAM, dp_if.filt_cnt_en, dp_if.ifg_cnt_en,
                    dp_if.ifmap_wen, busy, job_done, timeout_err});
    endfunction

    task automatic dp_idle();
        dp_if.co_onehot = 1'b0;
        dp_if.co_ifG    = 1'b0;
        dp_if.done_all  = 1'b0;
        dp_if.res_empty = 1'b1;
    endtask

    task automatic run_job(input vec_t v);
        int fc = 0, starts = 0, jd = 0, wc = 0, round_no = 1;
        int t_start = 0, t_done = -1, k, n;
        bit in_run = 0, ended = 0;
        logic [6:0] pat = 7'b1111011;
        logic [NP-1:0] exp_w;

        for (int r = 0; r < v.exp_starts; r++)
            for (int p = 0; p < NP; p++)
                for (int w = 0; w < IFW; w++)
                    exp_wen_q.push_back(NP'(1) << p);

        @(posedge clk); #1;
        start = 1'b1;
        {cfg_mode, cfg_filt_len, cfg_stride_len} = v.cfg;
        cfg_rounds = RW'(v.rounds);
        @(posedge clk); #1;
        start = 1'b0;
        check("first_timeout_clear", 32'(timeout_err), 0);
        check("cfg_latched", 32'({dp_if.mode, dp_if.filt_len, dp_if.stride_len}), 32'(v.cfg));

        for (n = 0; n < 3000; n++) begin
            dp_idle();
            if (!busy) begin
                ended = 1;
                break;
            end
            if (dp_if.filt_cnt_en) begin
                fc++;
                check("filt_sel", 32'(dp_if.sel_addr_SRAM), 0);
                dp_if.co_onehot = (fc == v.onehot_at);
            end
            if (dp_if.ifmap_wen != '0) begin
                if (exp_wen_q.size() == 0) begin
                    check("wen_unexpected", 32'(dp_if.ifmap_wen), 0);
                end else begin
                    exp_w = exp_wen_q.pop_front();
                    check("ifmap_wen", 32'(dp_if.ifmap_wen), 32'(exp_w));
                    check("if_sel_en", 32'({dp_if.sel_addr_SRAM, dp_if.ifg_cnt_en}), 3);
                end
                wc++;
                if (wc == NP * IFW) begin
                    if (round_no == v.ifg_round) dp_if.co_ifG = 1'b1;
                    round_no++;
                    wc = 0;
                end
            end
            if (dp_if.start_PE) begin
                starts++;
                t_start = cyc;
                in_run  = 1;
                check("start_enables_off",
                      32'({dp_if.filt_cnt_en, dp_if.ifg_cnt_en, dp_if.ifmap_wen}), 0);
            end else if (in_run && v.done_at != 0 && (cyc - t_start) == v.done_at) begin
                dp_if.done_all = 1'b1;
                in_run = 0;
                t_done = cyc;
            end
            if (v.toggle != 0 && t_done >= 0) begin
                k = cyc - t_done - 1;
                if (k >= 0 && k < 7) dp_if.res_empty = pat[k];
            end
            #1;
            if (job_done) begin
                jd++;
                check("done_gap", 32'(cyc - t_done), 32'(v.exp_gap));
            end
            @(posedge clk); #1;
        end

        check("job_terminates", 32'(ended), 1);
        check("filt_cycles", 32'(fc), 32'(v.onehot_at));
        check("start_pulses", 32'(starts), 32'(v.exp_starts));
        check("job_done_count", 32'(jd), 32'(v.exp_jd));
        check("timeout_flag", 32'(timeout_err), 32'(v.exp_to));
        check("wen_left", 32'(exp_wen_q.size()), 0);
        // Watchdog sees 0..all-ones over 2**TW RUN cycles, then one edge to IDLE.
        if (v.exp_to != 0) check("timeout_latency", 32'(cyc - t_start), 32'((1 << TW) + 1));
        exp_wen_q.delete();
    endtask

    task automatic wait_for_start_pe(output bit seen);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (dp_if.start_PE) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[8];

    initial begin
        int jd;
        bit seen;

        tbl[0] = '{1,  9, 20, 0, 0, 3'b101,  1, 1, 0, 5};
        tbl[1] = '{3,  9, 20, 0, 0, 3'b010,  3, 1, 0, 5};
        tbl[2] = '{0,  2,  5, 0, 0, 3'b111,  1, 1, 0, 5};
        tbl[3] = '{4,  4,  7, 2, 0, 3'b001,  2, 1, 0, 5};
        tbl[4] = '{2,  3,  0, 0, 0, 3'b100,  1, 0, 1, 0};
        tbl[5] = '{1,  1, 32, 0, 0, 3'b011,  1, 1, 0, 5};
        tbl[6] = '{1,  1,  1, 0, 1, 3'b110,  1, 1, 0, 8};
        tbl[7] = '{15, 1,  2, 0, 0, 3'b000, 15, 1, 0, 5};

        dp_idle();
        #1;
        check("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", all_outs(), 0);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Reset asserted in the middle of LOAD_IF.
        dp_if.co_onehot = 1'b1;
        start = 1'b1;
        {cfg_mode, cfg_filt_len, cfg_stride_len} = 3'b111;
        cfg_rounds = RW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && dp_if.ifmap_wen == '0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("mid_load_if_busy", 32'({busy, dp_if.ifg_cnt_en}), 3);
        rst = 1'b0;
        #1;
        check("reset_mid_op", all_outs(), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_mid_reset", all_outs(), 0);

        // Abort in RUN, with a start attempt while busy beforehand.
        start = 1'b1;
        {cfg_mode, cfg_filt_len, cfg_stride_len} = 3'b101;
        cfg_rounds = RW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_for_start_pe(seen);
        check("abort_seq_start_pe", 32'(seen), 1);
        dp_if.co_onehot = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        {cfg_mode, cfg_filt_len, cfg_stride_len} = 3'b010;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_while_busy", 32'({busy, dp_if.mode, dp_if.filt_len, dp_if.stride_len}), 32'b1101);
        abort = 1'b1;
        #1;
        check("abort_no_done", 32'(job_done), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_to_idle", 32'({busy, dp_if.filt_cnt_en, dp_if.ifg_cnt_en, dp_if.ifmap_wen}), 0);
        check("abort_cfg_kept", 32'({dp_if.mode, dp_if.filt_len, dp_if.stride_len}), 32'b101);
        jd = 0;
        for (int i = 0; i < 6; i++) begin
            if (job_done || busy) jd++;
            @(posedge clk); #1;
        end
        check("abort_stays_idle", 32'(jd), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

endmodule
